// File: rtl/vga_sync_decoder.sv
// Sync-pulse decoder: measures HS/VS periods, locks once they are stable and emits X/Y/DE.
// Optional 8-bit error counter on the ERR_CNT port when VGA_DEC_ERR_CNT_EN is defined.
module vga_sync_decoder #(
    parameter int CW          = 11,
    parameter int H_BP        = 184,
    parameter int H_ACT       = 800,
    parameter int V_BP        = 29,
    parameter int V_ACT       = 600,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          PIX_CLK,
    input  logic          RST,
    input  logic          HS,
    input  logic          VS,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          DE,
    output logic          LOCKED,
    output logic [CW-1:0] LINE_LEN,
`ifdef VGA_DEC_ERR_CNT_EN
    output logic [CW-1:0] FRAME_LEN,
    output logic [7:0]    ERR_CNT
`else
    output logic [CW-1:0] FRAME_LEN
`endif
);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] H_START = CW'(H_BP);
    localparam logic [CW-1:0] H_END   = CW'(H_BP + H_ACT);
    localparam logic [CW-1:0] V_START = CW'(V_BP);
    localparam logic [CW-1:0] V_END   = CW'(V_BP + V_ACT);
    localparam logic [3:0]    LOCK_N  = 4'(LOCK_FRAMES);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0] raw;
    logic [1:0] rise;
    logic       hs_rise, vs_rise;

    assign raw = {VS, HS};

    // Bit 0 carries HS, bit 1 carries VS: 2-FF synchronizer plus registered rising-edge pulse.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg, s2_reg, s3_reg, rise_reg;
            always_ff @(posedge PIX_CLK) begin
                if (RST) begin
                    s1_reg   <= 1'b0;
                    s2_reg   <= 1'b0;
                    s3_reg   <= 1'b0;
                    rise_reg <= 1'b0;
                end else begin
                    s1_reg   <= raw[gi];
                    s2_reg   <= s1_reg;
                    s3_reg   <= s2_reg;
                    rise_reg <= s2_reg & ~s3_reg;
                end
            end
            assign rise[gi] = rise_reg;
        end
    endgenerate

    assign hs_rise = rise[0];
    assign vs_rise = rise[1];

    logic [CW-1:0] hcnt_reg, vcnt_reg, line_len_reg, frame_len_reg;
    logic [CW-1:0] line_now, frame_now, line_cap;
    logic          timeout;

    // Captured periods saturate so a lost-sync line reads as the maximum, not as zero.
    assign line_now  = (hcnt_reg == CNT_MAX) ? CNT_MAX : hcnt_reg + 1'b1;
    assign frame_now = (vcnt_reg == CNT_MAX) ? CNT_MAX : vcnt_reg + 1'b1;
    assign line_cap  = hs_rise ? line_now : line_len_reg;
    assign timeout   = !hs_rise && (hcnt_reg == CNT_MAX - 1'b1);

    always_ff @(posedge PIX_CLK) begin
        if (RST) begin
            hcnt_reg      <= '0;
            vcnt_reg      <= '0;
            line_len_reg  <= '0;
            frame_len_reg <= '0;
        end else begin
            if (hs_rise) begin
                hcnt_reg     <= '0;
                line_len_reg <= line_now;
            end else if (hcnt_reg != CNT_MAX) begin
                hcnt_reg <= hcnt_reg + 1'b1;
            end
            if (vs_rise) begin
                vcnt_reg      <= '0;
                frame_len_reg <= frame_now;
            end else if (hs_rise && vcnt_reg != CNT_MAX) begin
                vcnt_reg <= vcnt_reg + 1'b1;
            end
        end
    end

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] ref_line_reg, ref_line_next, ref_frame_reg, ref_frame_next;
    logic [3:0]    match_reg, match_next;
    logic          line_bad_reg, line_bad_next;
    logic          line_mis, frame_mis, lock_mis;

    assign line_mis  = hs_rise && (line_now != ref_line_reg);
    assign frame_mis = frame_now != ref_frame_reg;
    assign lock_mis  = line_mis || (vs_rise && frame_mis);

    always_comb begin
        state_next     = state_reg;
        ref_line_next  = ref_line_reg;
        ref_frame_next = ref_frame_reg;
        match_next     = match_reg;
        line_bad_next  = line_bad_reg;
        case (state_reg)
            ST_SEARCH: begin
                if (vs_rise) begin
                    ref_line_next  = line_cap;
                    ref_frame_next = frame_now;
                    match_next     = '0;
                    line_bad_next  = 1'b0;
                    state_next     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (line_mis) line_bad_next = 1'b1;
                if (vs_rise) begin
                    if (!frame_mis && !line_bad_reg && !line_mis) begin
                        match_next = match_reg + 4'd1;
                        if (match_reg + 4'd1 >= LOCK_N) state_next = ST_LOCKED;
                    end else begin
                        ref_line_next  = line_cap;
                        ref_frame_next = frame_now;
                        match_next     = '0;
                        line_bad_next  = 1'b0;
                    end
                end
            end
            ST_LOCKED: begin
                if (lock_mis) begin
                    ref_line_next  = line_cap;
                    ref_frame_next = frame_now;
                    match_next     = '0;
                    line_bad_next  = 1'b0;
                    state_next     = ST_CHECK;
                end
            end
            default: state_next = ST_SEARCH;
        endcase
        if (timeout) begin
            state_next    = ST_SEARCH;
            match_next    = '0;
            line_bad_next = 1'b0;
        end
    end

    logic          h_act, v_act;
    logic [CW-1:0] x_reg, y_reg;
    logic          area_reg;

    assign h_act = (hcnt_reg >= H_START) && (hcnt_reg < H_END);
    assign v_act = (vcnt_reg >= V_START) && (vcnt_reg < V_END);

    always_ff @(posedge PIX_CLK) begin
        if (RST) begin
            state_reg     <= ST_SEARCH;
            ref_line_reg  <= '0;
            ref_frame_reg <= '0;
            match_reg     <= '0;
            line_bad_reg  <= 1'b0;
            x_reg         <= '0;
            y_reg         <= '0;
            area_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ref_line_reg  <= ref_line_next;
            ref_frame_reg <= ref_frame_next;
            match_reg     <= match_next;
            line_bad_reg  <= line_bad_next;
            x_reg         <= (h_act && v_act) ? hcnt_reg - H_START : '0;
            y_reg         <= (h_act && v_act) ? vcnt_reg - V_START : '0;
            area_reg      <= h_act && v_act;
        end
    end

    // DE is gated by the live lock state so it drops in the same cycle as LOCKED.
    assign LOCKED    = (state_reg == ST_LOCKED);
    assign DE        = area_reg & LOCKED;
    assign X         = x_reg;
    assign Y         = y_reg;
    assign LINE_LEN  = line_len_reg;
    assign FRAME_LEN = frame_len_reg;

`ifdef VGA_DEC_ERR_CNT_EN
    logic [7:0] err_reg;
    logic       err_event;

    assign err_event = timeout || (LOCKED && lock_mis);

    always_ff @(posedge PIX_CLK) begin
        if (RST) begin
            err_reg <= '0;
        end else if (err_event && err_reg != 8'hFF) begin
            err_reg <= err_reg + 8'd1;
        end
    end

    assign ERR_CNT = err_reg;
`endif
endmodule
